// File: rtl/perlin_ctrl_pkg.sv
// Shared widths, mode encoding and controller state for the Perlin animation controller.
package perlin_ctrl_pkg;

  localparam int COORD_W = 10;
  localparam int SPEED_W = 4;
  localparam int DIV_W   = 4;
  localparam int Z_W     = 8;

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_PAUSE = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAUSE,
    ST_STEP_ARM
  } ctrl_state_e;

  // Reserved mode 3 behaves like PAUSE.
  function automatic ctrl_state_e mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_RUN:  return ST_RUN;
      MODE_STEP: return ST_STEP_ARM;
      default:   return ST_PAUSE;
    endcase
  endfunction

endpackage

// File: rtl/perlin_scroll_axis.sv
// One scroll axis: wrapping offset accumulator plus the registered pixel+offset add
// with the two low coordinate bits cleared.
module perlin_scroll_axis #(
  parameter int COORD_W = 10,
  parameter int SPEED_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [SPEED_W-1:0] step,
  input  logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] noise_coord
);
  import perlin_ctrl_pkg::*;

  logic [COORD_W-1:0] offset;
  logic [COORD_W-1:0] step_ext;
  logic [COORD_W-1:0] coord_sum;

  assign step_ext  = {{(COORD_W-SPEED_W){step[SPEED_W-1]}}, step};
  assign coord_sum = px + offset;

  // Offset only moves on a tick, which only happens at frame_start (blanking).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset      <= '0;
      noise_coord <= '0;
    end else begin
      if (tick)
        offset <= offset + step_ext;
      noise_coord <= {coord_sum[COORD_W-1:2], 2'b00};
    end
  end

endmodule

// File: rtl/perlin_anim_ctrl.sv
// Frame-level animation controller: config handshake, frame-boundary apply,
// run/pause/step tick sequencing and the per-pixel noise coordinate path.
module perlin_anim_ctrl #(
  parameter int COORD_W = perlin_ctrl_pkg::COORD_W,
  parameter int SPEED_W = perlin_ctrl_pkg::SPEED_W,
  parameter int DIV_W   = perlin_ctrl_pkg::DIV_W,
  parameter int Z_W     = perlin_ctrl_pkg::Z_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x_px,
  input  logic [COORD_W-1:0] y_px,
  input  logic               activevideo,
  input  logic               frame_start,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [SPEED_W-1:0] cfg_dx,
  input  logic [SPEED_W-1:0] cfg_dy,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [1:0]         cfg_mode,
  output logic [COORD_W-1:0] noise_x,
  output logic [COORD_W-1:0] noise_y,
  output logic [Z_W-1:0]     noise_z,
  output logic               pix_en,
  output logic [7:0]         frame_count
);
  import perlin_ctrl_pkg::*;

  logic               pending;
  logic [SPEED_W-1:0] pend_dx;
  logic [SPEED_W-1:0] pend_dy;
  logic [DIV_W-1:0]   pend_div;
  logic [1:0]         pend_mode;

  logic [SPEED_W-1:0] act_dx;
  logic [SPEED_W-1:0] act_dy;
  logic [DIV_W-1:0]   act_div;
  logic [DIV_W-1:0]   div_cnt;
  ctrl_state_e        state;
  logic               tick;

  assign cfg_ready = ~pending;

  // Tick decision always uses the state and config in force before this edge.
  always_comb begin
    tick = 1'b0;
    if (frame_start) begin
      case (state)
        ST_RUN:      tick = (div_cnt == act_div);
        ST_STEP_ARM: tick = 1'b1;
        default:     tick = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      pend_dx     <= '0;
      pend_dy     <= '0;
      pend_div    <= '0;
      pend_mode   <= MODE_RUN;
      act_dx      <= '0;
      act_dy      <= '0;
      act_div     <= '0;
      div_cnt     <= '0;
      state       <= ST_RUN;
      noise_z     <= '0;
      frame_count <= '0;
      pix_en      <= 1'b0;
    end else begin
      pix_en <= activevideo;
      if (cfg_valid && !pending) begin
        pending   <= 1'b1;
        pend_dx   <= cfg_dx;
        pend_dy   <= cfg_dy;
        pend_div  <= cfg_div;
        pend_mode <= cfg_mode;
      end
      if (frame_start) begin
        frame_count <= frame_count + 8'd1;
        if (tick)
          noise_z <= noise_z + Z_W'(1);
        case (state)
          ST_RUN:      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
          ST_STEP_ARM: state <= ST_PAUSE;
          default:     ;
        endcase
        // A slot captured before this edge wins over the step-to-pause move above.
        if (pending) begin
          pending <= 1'b0;
          act_dx  <= pend_dx;
          act_dy  <= pend_dy;
          act_div <= pend_div;
          div_cnt <= '0;
          state   <= mode_to_state(pend_mode);
        end
      end
    end
  end

  perlin_scroll_axis #(
    .COORD_W(COORD_W),
    .SPEED_W(SPEED_W)
  ) u_axis_x (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .step       (act_dx),
    .px         (x_px),
    .noise_coord(noise_x)
  );

  perlin_scroll_axis #(
    .COORD_W(COORD_W),
    .SPEED_W(SPEED_W)
  ) u_axis_y (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .step       (act_dy),
    .px         (y_px),
    .noise_coord(noise_y)
  );

endmodule

// File: tb/tb_perlin_anim_ctrl.sv
// Scoreboard bench for perlin_anim_ctrl: each visible pixel pushes a hand-computed
// expectation, and a negedge monitor pops one whenever pix_en is presented.
module tb_perlin_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x_px = '0;
  logic [9:0] y_px = '0;
  logic       activevideo = 1'b0;
  logic       frame_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_dx = '0;
  logic [3:0] cfg_dy = '0;
  logic [3:0] cfg_div = '0;
  logic [1:0] cfg_mode = '0;
  logic [9:0] noise_x;
  logic [9:0] noise_y;
  logic [7:0] noise_z;
  logic       pix_en;
  logic [7:0] frame_count;

  typedef struct {
    int         id;
    logic [9:0] nx;
    logic [9:0] ny;
    logic [7:0] nz;
    logic [7:0] fc;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  perlin_anim_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_px       (x_px),
    .y_px       (y_px),
    .activevideo(activevideo),
    .frame_start(frame_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_dx     (cfg_dx),
    .cfg_dy     (cfg_dy),
    .cfg_div    (cfg_div),
    .cfg_mode   (cfg_mode),
    .noise_x    (noise_x),
    .noise_y    (noise_y),
    .noise_z    (noise_z),
    .pix_en     (pix_en),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_clk();
    tick_clk();
    rst_n = 1'b1;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick_clk();
      frame_start = 1'b0;
      tick_clk();
    end
  endtask

  task automatic send_cfg(input logic [3:0] dx, input logic [3:0] dy,
                          input logic [3:0] dv, input logic [1:0] md);
    int waited = 0;
    while (!cfg_ready && waited < 20) begin
      tick_clk();
      waited++;
    end
    if (!cfg_ready) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL cfg_ready_timeout: cfg_ready=%0b required 1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_dx = dx;
    cfg_dy = dy;
    cfg_div = dv;
    cfg_mode = md;
    tick_clk();
    cfg_valid = 1'b0;
  endtask

  // One visible pixel; its registered result is expected on the next pix_en.
  task automatic applyStimulus(input int id, input logic [9:0] x, input logic [9:0] y,
                               input logic [9:0] enx, input logic [9:0] eny,
                               input logic [7:0] enz, input logic [7:0] efc,
                               input logic erdy);
    exp_t e;
    e.id = id; e.nx = enx; e.ny = eny; e.nz = enz; e.fc = efc; e.rdy = erdy;
    sb_q.push_back(e);
    x_px = x;
    y_px = y;
    activevideo = 1'b1;
    tick_clk();
    activevideo = 1'b0;
    tick_clk();
  endtask

  task automatic checkOutput(input exp_t e);
    n_tests++;
    if (noise_x !== e.nx || noise_y !== e.ny || noise_z !== e.nz ||
        frame_count !== e.fc || cfg_ready !== e.rdy) begin
      n_fail++;
      $display("[TB] FAIL pixel_%0d: got x=%0d y=%0d z=%0d fc=%0d rdy=%0b, required x=%0d y=%0d z=%0d fc=%0d rdy=%0b",
               e.id, noise_x, noise_y, noise_z, frame_count, cfg_ready,
               e.nx, e.ny, e.nz, e.fc, e.rdy);
    end
  endtask

  always @(negedge clk) begin
    if (pix_en) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_pix_en: pix_en=1 with no expectation queued");
      end else begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset();
    // Reset state: offsets zero, low coordinate bits masked.
    applyStimulus(1, 10'd5, 10'd9, 10'd4, 10'd8, 8'd0, 8'd0, 1'b1);

    // dx=+2, dy=-1, div=0, RUN. The reset config (RUN, div 0, zero step) also ticks
    // on the apply edge, so z counts 3 while offsets only move twice.
    send_cfg(4'd2, 4'hF, 4'd0, 2'd0);
    applyStimulus(2, 10'd0, 10'd0, 10'd0, 10'd0, 8'd0, 8'd0, 1'b0);
    pulse_frames(3);
    applyStimulus(3, 10'd0, 10'd0, 10'd4, 10'd1020, 8'd3, 8'd3, 1'b1);
    applyStimulus(4, 10'd1, 10'd3, 10'd4, 10'd0, 8'd3, 8'd3, 1'b1);

    // div=2, dx=1, dy=0: apply edge ticks under old config (off 6/1021, z=4).
    send_cfg(4'd1, 4'd0, 4'd2, 2'd0);
    pulse_frames(1);
    pulse_frames(2);
    applyStimulus(5, 10'd0, 10'd0, 10'd4, 10'd1020, 8'd4, 8'd6, 1'b1);
    pulse_frames(1);
    applyStimulus(6, 10'd2, 10'd3, 10'd8, 10'd0, 8'd5, 8'd7, 1'b1);
    pulse_frames(4);
    applyStimulus(7, 10'd0, 10'd0, 10'd8, 10'd1020, 8'd6, 8'd11, 1'b1);

    // STEP dx=3 dy=1: one tick on the frame after apply, then PAUSE holds.
    send_cfg(4'd3, 4'd1, 4'd0, 2'd2);
    pulse_frames(3);
    applyStimulus(8, 10'd0, 10'd0, 10'd8, 10'd1020, 8'd7, 8'd14, 1'b1);
    pulse_frames(1);
    applyStimulus(9, 10'd1, 10'd2, 10'd12, 10'd0, 8'd7, 8'd15, 1'b1);

    // Transfer on the same edge as frame_start; a second request is ignored.
    cfg_valid = 1'b1; cfg_dx = 4'd1; cfg_dy = 4'd0; cfg_div = 4'd0; cfg_mode = 2'd0;
    frame_start = 1'b1;
    tick_clk();
    frame_start = 1'b0;
    cfg_dx = 4'd7; cfg_dy = 4'd7; cfg_div = 4'd5; cfg_mode = 2'd1;
    applyStimulus(10, 10'd0, 10'd0, 10'd8, 10'd1020, 8'd7, 8'd16, 1'b0);
    cfg_valid = 1'b0;
    pulse_frames(1);
    applyStimulus(11, 10'd0, 10'd0, 10'd8, 10'd1020, 8'd7, 8'd17, 1'b1);
    pulse_frames(1);
    applyStimulus(12, 10'd0, 10'd0, 10'd12, 10'd1020, 8'd8, 8'd18, 1'b1);

    // Wrap: reach off_x=1020 via a single STEP of -4, then +7 wraps to 3.
    do_reset();
    send_cfg(4'hC, 4'd0, 4'd0, 2'd2);
    pulse_frames(2);
    applyStimulus(13, 10'd0, 10'd0, 10'd1020, 10'd0, 8'd2, 8'd2, 1'b1);
    send_cfg(4'd7, 4'd0, 4'd0, 2'd0);
    pulse_frames(2);
    applyStimulus(14, 10'd0, 10'd0, 10'd0, 10'd0, 8'd3, 8'd4, 1'b1);
    applyStimulus(15, 10'd1, 10'd0, 10'd4, 10'd0, 8'd3, 8'd4, 1'b1);

    // Reset while a config is pending discards it.
    send_cfg(4'd5, 4'd5, 4'd0, 2'd0);
    applyStimulus(16, 10'd0, 10'd0, 10'd0, 10'd0, 8'd3, 8'd4, 1'b0);
    do_reset();
    applyStimulus(17, 10'd0, 10'd0, 10'd0, 10'd0, 8'd0, 8'd0, 1'b1);
    pulse_frames(1);
    applyStimulus(18, 10'd8, 10'd4, 10'd8, 10'd4, 8'd1, 8'd1, 1'b1);

    tick_clk();
    tick_clk();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
